// File: rtl/cim_stream_rx.sv
`default_nettype none
// ============================================================================
// Module      : cim_stream_rx
// Description : Receives parameter-stream and patch-broadcast loads from the
//               CiM bus and turns them into single-word memory write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module cim_stream_rx #(
    parameter int ID           = 0,
    parameter int N_LANES      = 3,
    parameter int N_STORAGE    = 16,
    parameter int ADDR_W       = 10,
    parameter int CNT_W        = 7,
    parameter int BCAST_BASE   = 0,
    parameter int NUM_CIMS     = 8,
    parameter int BUS_OP_WIDTH = 4,
    parameter logic [BUS_OP_WIDTH-1:0] PARAM_STREAM_START_OP          = 'd1,
    parameter logic [BUS_OP_WIDTH-1:0] PARAM_STREAM_OP                = 'd2,
    parameter logic [BUS_OP_WIDTH-1:0] PATCH_LOAD_BROADCAST_START_OP  = 'd3,
    parameter logic [BUS_OP_WIDTH-1:0] PATCH_LOAD_BROADCAST_OP        = 'd4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [BUS_OP_WIDTH-1:0]           bus_op,
    input  logic [N_LANES*N_STORAGE-1:0]      bus_data,
    input  logic [$clog2(NUM_CIMS)-1:0]       bus_target_or_sender,
    output logic                              mem_wr_en,
    output logic [ADDR_W-1:0]                 mem_wr_addr,
    output logic [N_STORAGE-1:0]              mem_wr_data,
    output logic                              is_ready,
    output logic                              done,
    output logic [CNT_W-1:0]                  word_cnt,
    output logic                              overflow_err
);

    localparam int TGT_W = $clog2(NUM_CIMS);
    localparam int LP_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int SUM_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

    localparam logic [TGT_W-1:0]  C_ID        = TGT_W'(ID);
    localparam logic [ADDR_W-1:0] C_BCAST     = ADDR_W'(BCAST_BASE);
    localparam logic [LP_W-1:0]   C_LAST_LANE = LP_W'(N_LANES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RX_TGT   = 2'd1,
        RX_BCAST = 2'd2
    } state_t;

    state_t                     r_state, w_nx_state;
    logic [BUS_OP_WIDTH-1:0]    r_op;
    logic [TGT_W-1:0]           r_tgt;
    logic [N_LANES*N_STORAGE-1:0] r_data;
    logic [ADDR_W-1:0]          r_base, w_nx_base;
    logic [CNT_W-1:0]           r_len, w_nx_len;
    logic [CNT_W-1:0]           r_word_cnt, w_nx_cnt, w_cnt_inc;
    logic [LP_W-1:0]            r_lane_ptr, w_nx_ptr;
    logic                       r_wr_en, w_nx_wr;
    logic [ADDR_W-1:0]          r_wr_addr, w_nx_addr;
    logic [N_STORAGE-1:0]       r_wr_data, w_nx_data, w_wdata;
    logic                       r_done, w_nx_done;
    logic                       r_ovf, w_nx_ovf;
    logic                       r_ready, w_nx_ready;
    logic                       w_take, w_start_tgt, w_start_bc;
    logic [SUM_W-1:0]           w_sum;
    logic                       w_sum_ovf;
    logic [N_STORAGE-1:0]       w_lanes [N_LANES];

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        assign w_lanes[k] = r_data[k*N_STORAGE +: N_STORAGE];
    end

    // Wide enough that neither base nor count is truncated before the range test
    assign w_sum       = SUM_W'(r_base) + SUM_W'(r_word_cnt);
    assign w_sum_ovf   = |w_sum[SUM_W-1:ADDR_W];
    assign w_cnt_inc   = r_word_cnt + 1'b1;
    assign w_start_tgt = (r_op == PARAM_STREAM_START_OP) && (r_tgt == C_ID);
    assign w_start_bc  = (r_op == PATCH_LOAD_BROADCAST_START_OP);

    always_comb begin
        w_nx_state = r_state;
        w_nx_base  = r_base;
        w_nx_len   = r_len;
        w_nx_cnt   = r_word_cnt;
        w_nx_ptr   = r_lane_ptr;
        w_nx_ovf   = r_ovf;
        w_nx_wr    = 1'b0;
        w_nx_addr  = r_wr_addr;
        w_nx_data  = r_wr_data;
        w_nx_done  = 1'b0;
        w_take     = 1'b0;
        w_wdata    = '0;

        if (w_start_tgt || w_start_bc) begin
            w_nx_base = w_start_tgt ? w_lanes[0][ADDR_W-1:0] : C_BCAST;
            w_nx_len  = w_lanes[1][CNT_W-1:0];
            w_nx_cnt  = '0;
            w_nx_ptr  = '0;
            if (w_lanes[1][CNT_W-1:0] == '0) begin
                w_nx_done  = 1'b1;
                w_nx_state = IDLE;
            end else begin
                w_nx_state = w_start_tgt ? RX_TGT : RX_BCAST;
            end
        end else if (r_state == RX_TGT && r_op == PARAM_STREAM_OP && r_tgt == C_ID) begin
            w_take   = 1'b1;
            w_wdata  = w_lanes[r_lane_ptr];
            w_nx_ptr = (r_lane_ptr == C_LAST_LANE) ? '0 : r_lane_ptr + 1'b1;
        end else if (r_state == RX_BCAST && r_op == PATCH_LOAD_BROADCAST_OP) begin
            w_take  = 1'b1;
            w_wdata = w_lanes[0];
        end

        // An out-of-range word still counts toward the load length
        if (w_take) begin
            w_nx_cnt = w_cnt_inc;
            if (w_sum_ovf) begin
                w_nx_ovf = 1'b1;
            end else begin
                w_nx_wr   = 1'b1;
                w_nx_addr = w_sum[ADDR_W-1:0];
                w_nx_data = w_wdata;
            end
            if (w_cnt_inc == r_len) begin
                w_nx_done  = 1'b1;
                w_nx_state = IDLE;
                w_nx_ptr   = '0;
            end
        end

        w_nx_ready = (w_nx_state != RX_TGT) || (w_nx_ptr == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_tgt      <= '0;
            r_data     <= '0;
            r_base     <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_lane_ptr <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_op       <= bus_op;
            r_tgt      <= bus_target_or_sender;
            r_data     <= bus_data;
            r_state    <= w_nx_state;
            r_base     <= w_nx_base;
            r_len      <= w_nx_len;
            r_word_cnt <= w_nx_cnt;
            r_lane_ptr <= w_nx_ptr;
            r_wr_en    <= w_nx_wr;
            r_wr_addr  <= w_nx_addr;
            r_wr_data  <= w_nx_data;
            r_done     <= w_nx_done;
            r_ovf      <= w_nx_ovf;
            r_ready    <= w_nx_ready;
        end
    end

    assign mem_wr_en    = r_wr_en;
    assign mem_wr_addr  = r_wr_addr;
    assign mem_wr_data  = r_wr_data;
    assign is_ready     = r_ready;
    assign done         = r_done;
    assign word_cnt     = r_word_cnt;
    assign overflow_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cim_stream_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cim_stream_rx
// Description : Scoreboard bench for cim_stream_rx (main and 4-bit-address DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cim_stream_rx;

    localparam logic [3:0] OP_NOP = 4'd0, OP_SS = 4'd1, OP_S = 4'd2, OP_BS = 4'd3, OP_B = 4'd4;
    localparam logic [47:0] LN = {16'h3333, 16'h2222, 16'h1111};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  op, op4;
    logic [47:0] data, data4;
    logic [2:0]  tgt, tgt4;

    logic        wr_en, done, is_ready, ovf;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic [6:0]  word_cnt;
    logic        wr_en4, done4, is_ready4, ovf4;
    logic [3:0]  wr_addr4;
    logic [15:0] wr_data4;
    logic [6:0]  word_cnt4;

    always #5 clk = ~clk;

    cim_stream_rx #(.ID(2), .ADDR_W(10), .BCAST_BASE(32'h080), .NUM_CIMS(8), .BUS_OP_WIDTH(4),
        .PARAM_STREAM_START_OP(OP_SS), .PARAM_STREAM_OP(OP_S),
        .PATCH_LOAD_BROADCAST_START_OP(OP_BS), .PATCH_LOAD_BROADCAST_OP(OP_B)) dut (
        .clk(clk), .rst_n(rst_n), .bus_op(op), .bus_data(data), .bus_target_or_sender(tgt),
        .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data), .is_ready(is_ready),
        .done(done), .word_cnt(word_cnt), .overflow_err(ovf));

    cim_stream_rx #(.ID(2), .ADDR_W(4), .BCAST_BASE(0), .NUM_CIMS(8), .BUS_OP_WIDTH(4),
        .PARAM_STREAM_START_OP(OP_SS), .PARAM_STREAM_OP(OP_S),
        .PATCH_LOAD_BROADCAST_START_OP(OP_BS), .PATCH_LOAD_BROADCAST_OP(OP_B)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus_op(op4), .bus_data(data4), .bus_target_or_sender(tgt4),
        .mem_wr_en(wr_en4), .mem_wr_addr(wr_addr4), .mem_wr_data(wr_data4), .is_ready(is_ready4),
        .done(done4), .word_cnt(word_cnt4), .overflow_err(ovf4));

    typedef struct packed {
        logic [31:0] due;
        logic        wr;
        logic [9:0]  addr;
        logic [15:0] data;
        logic        dn;
        logic        rdy;
        logic        ovf;
        logic [6:0]  cnt;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    ev_t a0, e0, a1, e1;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every write strobe or done pulse must match the next expected event
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (wr_en || done)) begin
            a0 = '{due: cyc, wr: wr_en, addr: wr_addr, data: wr_data, dn: done,
                   rdy: is_ready, ovf: ovf, cnt: word_cnt};
            if (q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL main_event: got %h expected none", a0);
            end else begin
                e0 = q0.pop_front();
                if (!e0.wr) begin a0.addr = '0; a0.data = '0; end
                check("main_event", 128'(a0), 128'(e0));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (wr_en4 || done4)) begin
            a1 = '{due: cyc, wr: wr_en4, addr: {6'd0, wr_addr4}, data: wr_data4, dn: done4,
                   rdy: is_ready4, ovf: ovf4, cnt: word_cnt4};
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a4_event: got %h expected none", a1);
            end else begin
                e1 = q1.pop_front();
                if (!e1.wr) begin a1.addr = '0; a1.data = '0; end
                check("a4_event", 128'(a1), 128'(e1));
            end
        end
    end

    // Drive one bus beat; if ev, queue the event expected two edges later
    task automatic beat(input bit which, input logic [3:0] o, input logic [2:0] t,
                        input logic [47:0] d, input bit ev, input bit wr,
                        input logic [9:0] a, input logic [15:0] wd, input bit dn,
                        input bit rdy, input bit ov, input logic [6:0] cnt);
        ev_t e;
        @(negedge clk);
        if (which) begin op4 = o; tgt4 = t; data4 = d; end
        else begin op = o; tgt = t; data = d; end
        e = '{due: cyc + 2, wr: wr, addr: wr ? a : 10'd0, data: wr ? wd : 16'd0,
              dn: dn, rdy: rdy, ovf: ov, cnt: cnt};
        if (ev) begin
            if (which) q1.push_back(e); else q0.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op = OP_NOP; op4 = OP_NOP; tgt = 3'd0; tgt4 = 3'd0;
        end
    endtask

    task automatic drain(input string name);
        int k;
        idle(1);
        k = 0;
        while ((q0.size() + q1.size()) != 0 && k < 20) begin
            idle(1);
            k++;
        end
        check(name, 128'(q0.size() + q1.size()), 128'd0);
        q0.delete();
        q1.delete();
    endtask

    task automatic reset_values(input string name);
        check({name, "_main"}, 128'({wr_en, wr_addr, wr_data, done, word_cnt, ovf, is_ready}),
              128'({1'b0, 10'h0, 16'h0, 1'b0, 7'h0, 1'b0, 1'b1}));
        check({name, "_a4"}, 128'({wr_en4, wr_addr4, wr_data4, done4, word_cnt4, ovf4, is_ready4}),
              128'({1'b0, 4'h0, 16'h0, 1'b0, 7'h0, 1'b0, 1'b1}));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        op = OP_NOP; op4 = OP_NOP; tgt = '0; tgt4 = '0; data = '0; data4 = '0;
        #1 rst_n = 1'b0;
        #1 reset_values("reset_initial");
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Targeted load: 6 words across two lane groups
        beat(0, OP_SS, 3'd2, {16'h0, 16'd6, 16'h040}, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h040, 16'h1111, 0, 0, 0, 7'd1);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h041, 16'h2222, 0, 0, 0, 7'd2);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h042, 16'h3333, 0, 1, 0, 7'd3);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h043, 16'h1111, 0, 0, 0, 7'd4);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h044, 16'h2222, 0, 0, 0, 7'd5);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h045, 16'h3333, 1, 1, 0, 7'd6);
        drain("drain_tgt");

        // Same load with foreign-target beats interleaved
        beat(0, OP_SS, 3'd2, {16'h0, 16'd6, 16'h040}, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd5, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h040, 16'h1111, 0, 0, 0, 7'd1);
        beat(0, OP_S,  3'd5, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h041, 16'h2222, 0, 0, 0, 7'd2);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h042, 16'h3333, 0, 1, 0, 7'd3);
        beat(0, OP_S,  3'd5, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h043, 16'h1111, 0, 0, 0, 7'd4);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h044, 16'h2222, 0, 0, 0, 7'd5);
        beat(0, OP_S,  3'd5, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h045, 16'h3333, 1, 1, 0, 7'd6);
        drain("drain_interleave");

        // Broadcast load, base 0x080; stream ops must be ignored in RX_BCAST
        beat(0, OP_BS, 3'd7, {16'h0, 16'd4, 16'hFFFF}, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd2, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            beat(0, OP_B, 3'd1, {16'hAAAA, 16'hBBBB, 16'(i)}, 1, 1, 10'(10'h080 + i - 1),
                 16'(i), (i == 4), 1, 0, 7'(i));
        beat(0, OP_B, 3'd1, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        drain("drain_bcast");

        // Zero-length load: done only
        beat(0, OP_SS, 3'd2, {16'h0, 16'd0, 16'h055}, 1, 0, 0, 0, 1, 1, 0, 7'd0);
        beat(0, OP_S,  3'd2, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        drain("drain_len0");

        // Restart mid-load
        beat(0, OP_SS, 3'd2, {16'h0, 16'd8, 16'h010}, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h010, 16'h1111, 0, 0, 0, 7'd1);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h011, 16'h2222, 0, 0, 0, 7'd2);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h012, 16'h3333, 0, 1, 0, 7'd3);
        beat(0, OP_SS, 3'd2, {16'h0, 16'd2, 16'h100}, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h100, 16'h1111, 0, 0, 0, 7'd1);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h101, 16'h2222, 1, 1, 0, 7'd2);
        beat(0, OP_S,  3'd2, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        drain("drain_restart");

        // Address overflow on the 4-bit-address instance
        beat(1, OP_SS, 3'd2, {16'h0, 16'd4, 16'h00E}, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(1, OP_S,  3'd2, LN, 1, 1, 10'd14, 16'h1111, 0, 0, 0, 7'd1);
        beat(1, OP_S,  3'd2, LN, 1, 1, 10'd15, 16'h2222, 0, 0, 0, 7'd2);
        beat(1, OP_S,  3'd2, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        check("ovf_after_beat3", 128'({ovf4, word_cnt4}), 128'({1'b1, 7'd3}));
        beat(1, OP_S,  3'd2, LN, 1, 0, 0, 0, 1, 1, 1, 7'd4);
        drain("drain_ovf");

        // Asynchronous reset mid-load after two writes
        beat(0, OP_SS, 3'd2, {16'h0, 16'd5, 16'h020}, 0, 0, 0, 0, 0, 0, 0, 0);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h020, 16'h1111, 0, 0, 0, 7'd1);
        beat(0, OP_S,  3'd2, LN, 1, 1, 10'h021, 16'h2222, 0, 0, 0, 7'd2);
        drain("drain_pre_reset");
        check("pre_reset_state", 128'({is_ready, word_cnt, ovf4}), 128'({1'b0, 7'd2, 1'b1}));
        #2 rst_n = 1'b0;
        #1 reset_values("reset_midload");
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            beat(0, OP_S, 3'd2, LN, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        check("post_reset_idle", 128'({word_cnt, is_ready, done}), 128'({7'd0, 1'b1, 1'b0}));
        drain("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
